// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 memory-side sequencer.
package l2_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int L2_ADDR_W  = 32;
    localparam int L2_OFS_W   = 6;
    localparam int L2_LINE_W  = 512;
    localparam int L2_BEAT_W  = 64;
    localparam int BEATS      = L2_LINE_W / L2_BEAT_W;
    localparam int BEAT_CNT_W = $clog2(BEATS);

    localparam int TIMEOUT_CYC = 4096;

    typedef logic [L2_ADDR_W-L2_OFS_W-1:0] L2_LINE_ADDR;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_AR   = 2'd1,
        RD_DATA = 2'd2,
        RD_RET  = 2'd3
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_AW   = 2'd1,
        WR_DATA = 2'd2,
        WR_B    = 2'd3
    } wr_state_e;

endpackage

// File: rtl/l2_line_serdes.sv
// Line buffer with beat counter: assembles beats into a line (R path) or
// holds a loaded line whose beats are sliced out by the counter (W path).
module l2_line_serdes
    import l2_pkg::*;
#(
    parameter int LINE_W = 512,
    parameter int BEAT_W = 64,
    parameter int CNT_W  = $clog2(LINE_W / BEAT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              wr_i,
    input  logic [BEAT_W-1:0] beat_i,
    input  logic              adv_i,
    output logic [LINE_W-1:0] line_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [LINE_W-1:0] line_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (load_i) begin
                line_q <= line_i;
            end else if (wr_i) begin
                line_q[int'(cnt_q) * BEAT_W +: BEAT_W] <= beat_i;
            end
            if (clr_i || load_i) begin
                cnt_q <= '0;
            end else if (adv_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign line_o = line_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/l2_mem_sched.sv
// Memory-side sequencer: one line fill (AR/R) and one writeback (AW/W/B) in flight.
// Optional watchdog on R/B waits: define L2_MEM_TIMEOUT_EN.
module l2_mem_sched
    import l2_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512,
    parameter int BEAT_W = 64,
    parameter int ID_W   = 4,
    parameter int OFS_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [ID_W-1:0]   rd_req_id,
    output logic              fill_valid,
    input  logic              fill_ready,
    output logic [ID_W-1:0]   fill_id,
    output logic [LINE_W-1:0] fill_data,
    output logic              fill_err,
    input  logic              wb_req_valid,
    output logic              wb_req_ready,
    input  logic [ADDR_W-1:0] wb_req_addr,
    input  logic [LINE_W-1:0] wb_req_data,
    output logic              wb_done,
    output logic              wb_err,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [7:0]        ar_len,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [BEAT_W-1:0] r_data,
    input  logic              r_last,
    input  logic [1:0]        r_resp,
    output logic              aw_valid,
    input  logic              aw_ready,
    output logic [ADDR_W-1:0] aw_addr,
    output logic [7:0]        aw_len,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [BEAT_W-1:0] w_data,
    output logic              w_last,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_resp,
    output logic              proto_err
);

    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int CNT_W  = $clog2(NBEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    rd_state_e         rd_state_q, rd_state_d;
    wr_state_e         wr_state_q, wr_state_d;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic [ID_W-1:0]   rd_id_q;
    logic              rd_err_q, rd_err_d;
    logic              wb_done_q, wb_done_d;
    logic              wb_err_q, wb_err_d;
    logic              proto_err_q;
    logic              rdy_en_q;
    logic              rd_acc, wr_acc, rd_perr, wr_perr;
    logic              rd_clr, rd_beat, wr_beat;
    logic              rd_hit, wr_hit, tie;
    logic              rd_to, wr_to;
    logic [CNT_W-1:0]  rd_cnt, wr_cnt;
    logic [LINE_W-1:0] wr_line;

    // A new request collides with the other side's in-flight line.
    assign rd_hit = (wr_state_q != WR_IDLE) &&
                    (rd_req_addr[ADDR_W-1:OFS_W] == wr_addr_q[ADDR_W-1:OFS_W]);
    assign wr_hit = (rd_state_q != RD_IDLE) &&
                    (wb_req_addr[ADDR_W-1:OFS_W] == rd_addr_q[ADDR_W-1:OFS_W]);
    assign tie    = rd_req_valid && wb_req_valid &&
                    (rd_state_q == RD_IDLE) && (wr_state_q == WR_IDLE) &&
                    (rd_req_addr[ADDR_W-1:OFS_W] == wb_req_addr[ADDR_W-1:OFS_W]);

`ifdef L2_MEM_TIMEOUT_EN
    logic [15:0] rd_wd_q, wr_wd_q;

    assign rd_to = (rd_state_q == RD_DATA) && !r_valid && (rd_wd_q == 16'(TIMEOUT_CYC - 1));
    assign wr_to = (wr_state_q == WR_B) && !b_valid && (wr_wd_q == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_wd_q <= '0;
            wr_wd_q <= '0;
        end else begin
            rd_wd_q <= ((rd_state_q == RD_DATA) && !r_valid && !rd_to) ? rd_wd_q + 16'd1 : 16'd0;
            wr_wd_q <= ((wr_state_q == WR_B) && !b_valid && !wr_to) ? wr_wd_q + 16'd1 : 16'd0;
        end
    end
`else
    assign rd_to = 1'b0;
    assign wr_to = 1'b0;
`endif

    always_comb begin
        rd_state_d   = rd_state_q;
        rd_err_d     = rd_err_q;
        rd_req_ready = 1'b0;
        ar_valid     = 1'b0;
        r_ready      = 1'b0;
        fill_valid   = 1'b0;
        rd_acc       = 1'b0;
        rd_clr       = 1'b0;
        rd_beat      = 1'b0;
        rd_perr      = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                rd_req_ready = rdy_en_q && !rd_hit && !tie;
                if (rd_req_valid && rdy_en_q && !rd_hit && !tie) begin
                    rd_acc     = 1'b1;
                    rd_state_d = RD_AR;
                end
            end
            RD_AR: begin
                ar_valid = 1'b1;
                if (ar_ready) begin
                    rd_clr     = 1'b1;
                    rd_err_d   = 1'b0;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    rd_beat = 1'b1;
                    if (r_resp != RESP_OKAY) rd_err_d = 1'b1;
                    // r_last must land exactly on the final beat; either side ends the burst.
                    if (r_last != (rd_cnt == LAST_BEAT)) begin
                        rd_perr  = 1'b1;
                        rd_err_d = 1'b1;
                    end
                    if (r_last || (rd_cnt == LAST_BEAT)) rd_state_d = RD_RET;
                end else if (rd_to) begin
                    rd_perr    = 1'b1;
                    rd_err_d   = 1'b1;
                    rd_state_d = RD_RET;
                end
            end
            RD_RET: begin
                fill_valid = 1'b1;
                if (fill_ready) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
        if (r_valid && (rd_state_q != RD_DATA)) rd_perr = 1'b1;
    end

    always_comb begin
        wr_state_d   = wr_state_q;
        wb_done_d    = 1'b0;
        wb_err_d     = 1'b0;
        wb_req_ready = 1'b0;
        aw_valid     = 1'b0;
        w_valid      = 1'b0;
        w_last       = 1'b0;
        b_ready      = 1'b0;
        wr_acc       = 1'b0;
        wr_beat      = 1'b0;
        wr_perr      = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                wb_req_ready = rdy_en_q && !wr_hit;
                if (wb_req_valid && rdy_en_q && !wr_hit) begin
                    wr_acc     = 1'b1;
                    wr_state_d = WR_AW;
                end
            end
            WR_AW: begin
                aw_valid = 1'b1;
                if (aw_ready) wr_state_d = WR_DATA;
            end
            WR_DATA: begin
                w_valid = 1'b1;
                w_last  = (wr_cnt == LAST_BEAT);
                if (w_ready) begin
                    wr_beat = 1'b1;
                    if (wr_cnt == LAST_BEAT) wr_state_d = WR_B;
                end
            end
            WR_B: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    wb_done_d  = 1'b1;
                    wb_err_d   = (b_resp != RESP_OKAY);
                    wr_state_d = WR_IDLE;
                end else if (wr_to) begin
                    wb_done_d  = 1'b1;
                    wb_err_d   = 1'b1;
                    wr_perr    = 1'b1;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
        if (b_valid && (wr_state_q != WR_B)) wr_perr = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q  <= RD_IDLE;
            wr_state_q  <= WR_IDLE;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            rd_id_q     <= '0;
            rd_err_q    <= 1'b0;
            wb_done_q   <= 1'b0;
            wb_err_q    <= 1'b0;
            proto_err_q <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            wr_state_q  <= wr_state_d;
            rd_err_q    <= rd_err_d;
            wb_done_q   <= wb_done_d;
            wb_err_q    <= wb_err_d;
            proto_err_q <= proto_err_q | rd_perr | wr_perr;
            rdy_en_q    <= 1'b1;
            if (rd_acc) begin
                rd_addr_q <= rd_req_addr;
                rd_id_q   <= rd_req_id;
            end
            if (wr_acc) wr_addr_q <= wb_req_addr;
        end
    end

    l2_line_serdes #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .CNT_W(CNT_W)) u_rd_buf (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (rd_clr),
        .load_i (1'b0),
        .line_i ('0),
        .wr_i   (rd_beat),
        .beat_i (r_data),
        .adv_i  (rd_beat),
        .line_o (fill_data),
        .cnt_o  (rd_cnt)
    );

    l2_line_serdes #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .CNT_W(CNT_W)) u_wr_buf (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (1'b0),
        .load_i (wr_acc),
        .line_i (wb_req_data),
        .wr_i   (1'b0),
        .beat_i ('0),
        .adv_i  (wr_beat),
        .line_o (wr_line),
        .cnt_o  (wr_cnt)
    );

    assign w_data    = wr_line[int'(wr_cnt) * BEAT_W +: BEAT_W];
    assign ar_addr   = rd_addr_q;
    assign aw_addr   = wr_addr_q;
    assign ar_len    = 8'(NBEATS - 1);
    assign aw_len    = 8'(NBEATS - 1);
    assign fill_id   = rd_id_q;
    assign fill_err  = rd_err_q;
    assign wb_done   = wb_done_q;
    assign wb_err    = wb_err_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_l2_mem_sched.sv
// Directed bench for l2_mem_sched with a zero-wait memory responder.
module tb_l2_mem_sched;

    logic         clk;
    logic         rst;
    logic         rd_req_valid, rd_req_ready;
    logic [31:0]  rd_req_addr;
    logic [3:0]   rd_req_id;
    logic         fill_valid, fill_ready;
    logic [3:0]   fill_id;
    logic [511:0] fill_data;
    logic         fill_err;
    logic         wb_req_valid, wb_req_ready;
    logic [31:0]  wb_req_addr;
    logic [511:0] wb_req_data;
    logic         wb_done, wb_err;
    logic         ar_valid, ar_ready;
    logic [31:0]  ar_addr;
    logic [7:0]   ar_len;
    logic         r_valid, r_ready;
    logic [63:0]  r_data;
    logic         r_last;
    logic [1:0]   r_resp;
    logic         aw_valid, aw_ready;
    logic [31:0]  aw_addr;
    logic [7:0]   aw_len;
    logic         w_valid, w_ready;
    logic [63:0]  w_data;
    logic         w_last;
    logic         b_valid, b_ready;
    logic [1:0]   b_resp;
    logic         proto_err;

    l2_mem_sched dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_id(rd_req_id),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_id(fill_id),
        .fill_data(fill_data), .fill_err(fill_err),
        .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
        .wb_req_addr(wb_req_addr), .wb_req_data(wb_req_data),
        .wb_done(wb_done), .wb_err(wb_err),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .r_resp(r_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wdat(input int k);
        return 64'hC0DE_0000_0000_0000 + 64'(k) * 64'h0101;
    endfunction

    // Responder knobs and observation state
    int           last_idx = 7;
    bit           w_toggle = 1'b0;
    int           b_delay  = 0;
    int           bwait    = 0;
    int           rk = 0, wk = 0, cyc = 0;
    int           ar_cyc = 0, b_cyc = 0, wbd_cyc = 0, fill_cyc = 0, rdacc_cyc = 0;
    int           fill_cnt = 0, wbd_cnt = 0;
    logic [31:0]  ar_addr_cap, aw_addr_cap;
    logic [7:0]   ar_len_cap, aw_len_cap, wlast_mask;
    logic [63:0]  wcap [8];
    logic [511:0] fcap;
    logic [3:0]   fid;
    logic         ferr, wbd_err;

    initial begin
        r_valid = 1'b0; r_data = '0; r_last = 1'b0; r_resp = 2'b00;
        b_valid = 1'b0; b_resp = 2'b00; w_ready = 1'b1;
        forever begin
            @(negedge clk);
            r_valid = r_ready;
            r_data  = 64'((rk + 1) * 17);
            r_last  = (rk == last_idx);
            if (b_ready) bwait++; else bwait = 0;
            b_valid = b_ready && (bwait > b_delay);
            w_ready = w_toggle ? ~w_ready : 1'b1;
        end
    end

    always @(posedge clk) begin
        if (ar_valid && ar_ready) begin
            ar_cyc = cyc; ar_addr_cap = ar_addr; ar_len_cap = ar_len; rk = 0;
        end else if (r_valid && r_ready) begin
            rk++;
        end
        if (aw_valid && aw_ready) begin
            aw_addr_cap = aw_addr; aw_len_cap = aw_len; wk = 0; wlast_mask = '0;
        end else if (w_valid && w_ready) begin
            if (wk < 8) begin
                wcap[wk] = w_data;
                wlast_mask[wk] = w_last;
            end
            wk++;
        end
        if (b_valid && b_ready) b_cyc = cyc;
        if (wb_done) begin
            wbd_cnt++; wbd_cyc = cyc; wbd_err = wb_err;
        end
        if (fill_valid && fill_ready) begin
            fill_cnt++; fill_cyc = cyc; fcap = fill_data; fid = fill_id; ferr = fill_err;
        end
        if (rd_req_valid && rd_req_ready) rdacc_cyc = cyc;
        cyc++;
    end

    task automatic issue_rd(input logic [31:0] a, input logic [3:0] id, input int budget,
                            output int waited);
        rd_req_valid = 1'b1; rd_req_addr = a; rd_req_id = id; waited = 0;
        #1;
        while (!rd_req_ready && waited < budget) begin
            @(negedge clk); #1; waited++;
        end
        @(negedge clk);
        rd_req_valid = 1'b0;
    endtask

    task automatic issue_wb(input logic [31:0] a, input int budget, output int waited);
        wb_req_valid = 1'b1; wb_req_addr = a; waited = 0;
        for (int k = 0; k < 8; k++) wb_req_data[k*64 +: 64] = wdat(k);
        #1;
        while (!wb_req_ready && waited < budget) begin
            @(negedge clk); #1; waited++;
        end
        @(negedge clk);
        wb_req_valid = 1'b0;
    endtask

    task automatic wait_fill(input int target, input string tag);
        int n = 0;
        while (fill_cnt < target && n < 300) begin
            @(negedge clk); n++;
        end
        chk(tag, 64'(fill_cnt >= target), 64'd1);
    endtask

    task automatic wait_wbd(input int target, input string tag);
        int n = 0;
        while (wbd_cnt < target && n < 300) begin
            @(negedge clk); n++;
        end
        chk(tag, 64'(wbd_cnt >= target), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w, n, f0, d0;
        rst = 1'b0;
        rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_id = '0;
        wb_req_valid = 1'b0; wb_req_addr = '0; wb_req_data = '0;
        fill_ready = 1'b1; ar_ready = 1'b1; aw_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_rd_rdy", 64'(rd_req_ready), 64'd0);
        chk("rst_wb_rdy", 64'(wb_req_ready), 64'd0);
        chk("rst_ar_vld", 64'(ar_valid), 64'd0);
        chk("rst_w_vld", 64'(w_valid), 64'd0);
        chk("rst_fill_vld", 64'(fill_valid), 64'd0);
        chk("rst_wb_done", 64'(wb_done), 64'd0);
        chk("rst_perr", 64'(proto_err), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_rd_rdy", 64'(rd_req_ready), 64'd1);
        chk("post_rst_wb_rdy", 64'(wb_req_ready), 64'd1);

        // Plain fill
        issue_rd(32'h1000, 4'd3, 20, w);
        chk("t1_acc", 64'(w), 64'd0);
        wait_fill(1, "t1_fill_seen");
        chk("t1_ar_addr", 64'(ar_addr_cap), 64'h1000);
        chk("t1_ar_len", 64'(ar_len_cap), 64'd7);
        chk("t1_latency", 64'(fill_cyc - ar_cyc), 64'd9);
        chk("t1_beat0", fcap[63:0], 64'h11);
        chk("t1_beat3", fcap[255:192], 64'h44);
        chk("t1_beat7", fcap[511:448], 64'h88);
        chk("t1_id", 64'(fid), 64'd3);
        chk("t1_err", 64'(ferr), 64'd0);

        // Writeback with stalling W channel
        w_toggle = 1'b1;
        issue_wb(32'h2040, 20, w);
        wait_wbd(1, "t2_done_seen");
        w_toggle = 1'b0;
        chk("t2_aw_addr", 64'(aw_addr_cap), 64'h2040);
        chk("t2_aw_len", 64'(aw_len_cap), 64'd7);
        chk("t2_nbeats", 64'(wk), 64'd8);
        for (int k = 0; k < 8; k++) chk($sformatf("t2_wdata%0d", k), wcap[k], wdat(k));
        chk("t2_wlast", 64'(wlast_mask), 64'h80);
        chk("t2_done_lat", 64'(wbd_cyc - b_cyc), 64'd1);
        chk("t2_err", 64'(wbd_err), 64'd0);

        // Hazard: read to a line being written stalls, unrelated read overlaps
        b_delay = 10;
        d0 = wbd_cnt; f0 = fill_cnt;
        issue_wb(32'h3000, 20, w);
        issue_rd(32'h4000, 4'd1, 20, w);
        chk("t3_other_acc", 64'(w), 64'd0);
        wait_fill(f0 + 1, "t3_other_fill");
        chk("t3_overlap", 64'(wbd_cnt), 64'(d0));
        rd_req_valid = 1'b1; rd_req_addr = 32'h3020; rd_req_id = 4'd2;
        #1;
        chk("t3_haz_rdy", 64'(rd_req_ready), 64'd0);
        issue_rd(32'h3020, 4'd2, 80, w);
        chk("t3_haz_acc", 64'(w < 80), 64'd1);
        chk("t3_wb_first", 64'(wbd_cnt), 64'(d0 + 1));
        chk("t3_acc_after", 64'(rdacc_cyc >= wbd_cyc && rdacc_cyc <= wbd_cyc + 1), 64'd1);
        wait_fill(f0 + 2, "t3_haz_fill");
        chk("t3_haz_id", 64'(fid), 64'd2);
        b_delay = 0;

        // Same-cycle read and writeback to one line
        d0 = wbd_cnt; f0 = fill_cnt;
        rd_req_valid = 1'b1; rd_req_addr = 32'h5000; rd_req_id = 4'd6;
        wb_req_valid = 1'b1; wb_req_addr = 32'h5000;
        for (int k = 0; k < 8; k++) wb_req_data[k*64 +: 64] = wdat(k);
        #1;
        chk("t4_wb_rdy", 64'(wb_req_ready), 64'd1);
        chk("t4_rd_rdy", 64'(rd_req_ready), 64'd0);
        @(negedge clk);
        wb_req_valid = 1'b0;
        n = 0;
        #1;
        while (!rd_req_ready && n < 60) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        rd_req_valid = 1'b0;
        chk("t4_rd_acc", 64'(n < 60), 64'd1);
        chk("t4_wb_first", 64'(wbd_cnt), 64'(d0 + 1));
        chk("t4_acc_after", 64'(rdacc_cyc >= wbd_cyc), 64'd1);
        wait_fill(f0 + 1, "t4_fill");

        // Early r_last, then a clean read
        f0 = fill_cnt;
        last_idx = 5;
        issue_rd(32'h6000, 4'd5, 20, w);
        wait_fill(f0 + 1, "t5_fill");
        last_idx = 7;
        chk("t5_ferr", 64'(ferr), 64'd1);
        chk("t5_perr", 64'(proto_err), 64'd1);
        chk("t5_beat5", fcap[383:320], 64'h66);
        issue_rd(32'h6040, 4'd7, 20, w);
        wait_fill(f0 + 2, "t5_fill2");
        chk("t5_ferr2", 64'(ferr), 64'd0);
        chk("t5_perr_sticky", 64'(proto_err), 64'd1);
        chk("t5_id2", 64'(fid), 64'd7);

        // Reset in the middle of a W burst
        d0 = wbd_cnt;
        issue_wb(32'h7000, 20, w);
        n = 0;
        while (wk != 3 && n < 50) begin
            @(negedge clk); n++;
        end
        chk("t6_reach_beat3", 64'(wk), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_w_vld", 64'(w_valid), 64'd0);
        chk("t6_aw_vld", 64'(aw_valid), 64'd0);
        chk("t6_ar_vld", 64'(ar_valid), 64'd0);
        chk("t6_fill_vld", 64'(fill_valid), 64'd0);
        chk("t6_perr_clr", 64'(proto_err), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_rd_rdy", 64'(rd_req_ready), 64'd1);
        chk("t6_wb_rdy", 64'(wb_req_ready), 64'd1);
        repeat (15) @(negedge clk);
        chk("t6_no_done", 64'(wbd_cnt), 64'(d0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
